// File: rtl/fb_arbiter_pkg.sv
// Shared framebuffer geometry, RGB565 width, clear FSM encoding and write-FIFO entry layout.
// Row base uses shift-adds so no multiplier is inferred for the 160-pixel stride.
package fb_arbiter_pkg;

  localparam int FB_W        = 160;
  localparam int FB_H        = 120;
  localparam int SCALE_SHIFT = 2;
  localparam int FB_SIZE     = 19200;
  localparam int RGB_W       = 16;
  localparam int ADDR_W      = 15;
  localparam int X_W         = 8;
  localparam int Y_W         = 7;
  localparam int WR_ENT_W    = X_W + Y_W + RGB_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [RGB_W-1:0] color;
  } wr_ent_t;

  // y * 160 == (y << 7) + (y << 5)
  function automatic logic [ADDR_W-1:0] fb_row_base(input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] y_ext;
    y_ext = ADDR_W'(y);
    return (y_ext << 7) + (y_ext << 5);
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Pointer/count write FIFO; entries poppable the cycle after push, no bypass.
// o_push_rdy comes from registered occupancy only, so a full FIFO refuses even when popping.
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 31
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push_vld,
  input  logic [WIDTH-1:0] i_push_dat,
  output logic             o_push_rdy,
  output logic             o_pop_vld,
  output logic [WIDTH-1:0] o_pop_dat,
  input  logic             i_pop_rdy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_push_rdy = (r_count != CNT_FULL);
  assign o_pop_vld  = (r_count != '0);
  assign w_push     = i_push_vld && o_push_rdy;
  assign w_pop      = i_pop_rdy && o_pop_vld;
  assign o_pop_dat  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scan read > clear fill > FIFO write; port outputs combinational.
// Scan data returns one cycle later; writes stall in the FIFO while scan or clear owns the port.
module fb_arbiter #(
  parameter int FB_W        = fb_arbiter_pkg::FB_W,
  parameter int FB_H        = fb_arbiter_pkg::FB_H,
  parameter int SCALE_SHIFT = fb_arbiter_pkg::SCALE_SHIFT,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic [9:0]  vga_xpos,
  input  logic [9:0]  vga_ypos,
  output logic [15:0] vga_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_x,
  input  logic [6:0]  wr_y,
  input  logic [15:0] wr_color,
  input  logic        clear_start,
  input  logic [15:0] clear_color,
  output logic        clear_busy,
  output logic        clear_done,
  output logic [14:0] fb_addr,
  output logic        fb_we,
  output logic [15:0] fb_wdata,
  input  logic [15:0] fb_rdata
);

  import fb_arbiter_pkg::*;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_W * FB_H - 1);

  logic              w_scan_req;
  logic [9:0]        w_col_m1;
  logic [9:0]        w_row_m1;
  logic [X_W-1:0]    w_scan_col;
  logic [Y_W-1:0]    w_scan_row;
  logic [ADDR_W-1:0] w_scan_addr;
  logic              r_rd_q;

  assign w_scan_req  = (vga_xpos != 10'd0) && (vga_ypos != 10'd0);
  assign w_col_m1    = vga_xpos - 10'd1;
  assign w_row_m1    = vga_ypos - 10'd1;
  assign w_scan_col  = X_W'(w_col_m1 >> SCALE_SHIFT);
  assign w_scan_row  = Y_W'(w_row_m1 >> SCALE_SHIFT);
  assign w_scan_addr = fb_row_base(w_scan_row) + ADDR_W'(w_scan_col);

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      r_rd_q <= 1'b0;
    end else begin
      r_rd_q <= w_scan_req;
    end
  end

  assign vga_data = r_rd_q ? fb_rdata : '0;

  wr_ent_t           w_push_ent;
  wr_ent_t           w_pop_ent;
  logic              w_fifo_vld;
  logic              w_fifo_rdy;
  logic              w_fifo_pop;
  logic              w_pop_in_range;
  logic [ADDR_W-1:0] w_pop_addr;

  assign w_push_ent = '{x: wr_x, y: wr_y, color: wr_color};

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WR_ENT_W)
  ) u_wr_fifo (
    .i_clk      (vga_clk),
    .i_rst_n    (rst_n),
    .i_push_vld (wr_valid),
    .i_push_dat (w_push_ent),
    .o_push_rdy (w_fifo_rdy),
    .o_pop_vld  (w_fifo_vld),
    .o_pop_dat  (w_pop_ent),
    .i_pop_rdy  (w_fifo_pop)
  );

  assign wr_ready       = w_fifo_rdy;
  assign w_pop_in_range = (int'(w_pop_ent.x) < FB_W) && (int'(w_pop_ent.y) < FB_H);
  assign w_pop_addr     = fb_row_base(w_pop_ent.y) + ADDR_W'(w_pop_ent.x);

  clr_state_t        r_state;
  clr_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_cnt_nxt;
  logic [RGB_W-1:0]  r_clr_color;
  logic [RGB_W-1:0]  w_clr_color_nxt;
  logic              r_clr_done;
  logic              w_clr_done_nxt;
  logic              w_clr_win;

  // The FIFO is locked out for the whole clear so queued pixels land on top of the fill.
  assign w_clr_win = !w_scan_req && (r_state == ST_CLEAR);

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_clr_cnt   <= '0;
      r_clr_color <= '0;
      r_clr_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_cnt   <= w_clr_cnt_nxt;
      r_clr_color <= w_clr_color_nxt;
      r_clr_done  <= w_clr_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_clr_cnt_nxt   = r_clr_cnt;
    w_clr_color_nxt = r_clr_color;
    w_clr_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_start) begin
          w_clr_color_nxt = clear_color;
          w_clr_cnt_nxt   = '0;
          w_state_nxt     = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (w_clr_win) begin
          if (r_clr_cnt == CLR_LAST) begin
            w_clr_cnt_nxt  = '0;
            w_clr_done_nxt = 1'b1;
            w_state_nxt    = ST_IDLE;
          end else begin
            w_clr_cnt_nxt = r_clr_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign clear_busy = (r_state == ST_CLEAR);
  assign clear_done = r_clr_done;

  always_comb begin
    fb_addr    = '0;
    fb_we      = 1'b0;
    fb_wdata   = '0;
    w_fifo_pop = 1'b0;
    if (w_scan_req) begin
      fb_addr = w_scan_addr;
    end else if (w_clr_win) begin
      fb_addr  = r_clr_cnt;
      fb_we    = 1'b1;
      fb_wdata = r_clr_color;
    end else if (w_fifo_vld) begin
      // Off-screen entries still consume their slot so the queue keeps moving.
      w_fifo_pop = 1'b1;
      if (w_pop_in_range) begin
        fb_addr  = w_pop_addr;
        fb_we    = 1'b1;
        fb_wdata = w_pop_ent.color;
      end
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scan/write/backpressure/clear/reset steps, then random traffic
// scored against a pixel-level model (ordered write list plus last-value image read back via scan).
module tb_fb_arbiter;

  logic        vga_clk;
  logic        rst_n;
  logic [9:0]  vga_xpos;
  logic [9:0]  vga_ypos;
  logic [15:0] vga_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [15:0] wr_color;
  logic        clear_start;
  logic [15:0] clear_color;
  logic        clear_busy;
  logic        clear_done;
  logic [14:0] fb_addr;
  logic        fb_we;
  logic [15:0] fb_wdata;
  logic [15:0] fb_rdata;

  logic        use_ram;
  logic [15:0] tb_rdata;
  logic [15:0] ram_q;
  logic [15:0] ram [0:32767];

  int vectors;
  int miscompares;

  int nwr, bad, busy_bad, early_done, ndone, nwe, nrd, exp_addr;
  bit last_seen, fin;
  logic [30:0] exp_q [$];
  logic [30:0] head;
  logic [15:0] exp_fb [int];

  fb_arbiter dut (
    .vga_clk     (vga_clk),
    .rst_n       (rst_n),
    .vga_xpos    (vga_xpos),
    .vga_ypos    (vga_ypos),
    .vga_data    (vga_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_color    (wr_color),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .fb_addr     (fb_addr),
    .fb_we       (fb_we),
    .fb_wdata    (fb_wdata),
    .fb_rdata    (fb_rdata)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Behavioural single-port RAM with one-cycle read latency.
  assign fb_rdata = use_ram ? ram_q : tb_rdata;
  always @(posedge vga_clk) begin
    if (fb_we) ram[fb_addr] <= fb_wdata;
    ram_q <= ram[fb_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge vga_clk);
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; vga_xpos = '0; vga_ypos = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
    clear_start = 1'b0; clear_color = '0;
    use_ram = 1'b0; tb_rdata = 16'h5555;

    // Reset state
    repeat (3) cyc();
    @(negedge vga_clk);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_vga_data", vga_data, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    rst_n = 1'b1;
    cyc();

    // Scan read mapping (5,9) -> 321, data one cycle later
    vga_xpos = 10'd5; vga_ypos = 10'd9;
    @(negedge vga_clk);
    chk("scan_addr", fb_addr, 321);
    chk("scan_we", fb_we, 0);
    cyc();
    vga_xpos = '0; vga_ypos = '0; tb_rdata = 16'hABCD;
    @(negedge vga_clk);
    chk("scan_data", vga_data, 16'hABCD);
    cyc();
    @(negedge vga_clk);
    chk("scan_data_idle", vga_data, 0);
    cyc();

    // Blanking write (10,3) -> 490 the cycle after push
    wr_valid = 1'b1; wr_x = 8'd10; wr_y = 7'd3; wr_color = 16'hF800;
    @(negedge vga_clk);
    chk("bw_ready", wr_ready, 1);
    chk("bw_we_push_cycle", fb_we, 0);
    cyc();
    wr_valid = 1'b0;
    @(negedge vga_clk);
    chk("bw_we", fb_we, 1);
    chk("bw_addr", fb_addr, 490);
    chk("bw_wdata", fb_wdata, 16'hF800);
    cyc();
    @(negedge vga_clk);
    chk("bw_we_after", fb_we, 0);
    cyc();

    // Backpressure: fill during scan, extra push refused, 4 writes on release
    vga_xpos = 10'd1; vga_ypos = 10'd1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_x = 8'(i); wr_y = 7'(i + 1); wr_color = 16'(16'h1000 + i);
      @(negedge vga_clk);
      chk("bp_we_scan", fb_we, 0);
      cyc();
    end
    wr_x = 8'd99; wr_y = 7'd99; wr_color = 16'hFFFF;
    @(negedge vga_clk);
    chk("bp_ready_full", wr_ready, 0);
    cyc();
    wr_valid = 1'b0; vga_xpos = '0; vga_ypos = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge vga_clk);
      chk("bp_drain_we", fb_we, 1);
      chk("bp_drain_addr", fb_addr, (i + 1) * 160 + i);
      chk("bp_drain_wdata", fb_wdata, 32'h1000 + i);
      cyc();
    end
    @(negedge vga_clk);
    chk("bp_drain_end_we", fb_we, 0);
    chk("bp_ready_after", wr_ready, 1);
    cyc();

    // Off-screen entries are popped silently; valid entry behind them still lands
    wr_valid = 1'b1; wr_x = 8'd160; wr_y = 7'd5; wr_color = 16'h1111;
    @(negedge vga_clk);
    chk("disc_ready", wr_ready, 1);
    chk("disc_we0", fb_we, 0);
    cyc();
    wr_x = 8'd0; wr_y = 7'd120; wr_color = 16'h2222;
    @(negedge vga_clk);
    chk("disc_we_x", fb_we, 0);
    cyc();
    wr_x = 8'd1; wr_y = 7'd0; wr_color = 16'h0F0F;
    @(negedge vga_clk);
    chk("disc_we_y", fb_we, 0);
    cyc();
    wr_valid = 1'b0;
    @(negedge vga_clk);
    chk("disc_next_we", fb_we, 1);
    chk("disc_next_addr", fb_addr, 1);
    chk("disc_next_wdata", fb_wdata, 16'h0F0F);
    cyc();

    // Full-frame clear with ignored restart, scan pause and a parked FIFO write
    use_ram = 1'b1;
    clear_start = 1'b1; clear_color = 16'h001F;
    @(negedge vga_clk);
    chk("clr_busy_pre", clear_busy, 0);
    cyc();
    clear_start = 1'b0; clear_color = '0;
    nwr = 0; bad = 0; busy_bad = 0; early_done = 0; last_seen = 0; fin = 0;
    for (int k = 0; k < 25000 && !fin; k++) begin
      clear_start = (k == 100);
      clear_color = (k == 100) ? 16'h07E0 : 16'h0000;
      wr_valid = (k == 200); wr_x = 8'd2; wr_y = 7'd2; wr_color = 16'hAAAA;
      if (k >= 300 && k < 310) begin
        vga_xpos = 10'(1 + (k - 300) * 4); vga_ypos = 10'd1;
      end else begin
        vga_xpos = '0; vga_ypos = '0;
      end
      @(negedge vga_clk);
      if (last_seen) begin
        chk("clr_done_pulse", clear_done, 1);
        chk("clr_busy_end", clear_busy, 0);
        chk("clr_fifo_we", fb_we, 1);
        chk("clr_fifo_addr", fb_addr, 322);
        chk("clr_fifo_wdata", fb_wdata, 16'hAAAA);
        fin = 1;
      end else begin
        if (clear_done) early_done++;
        if (!clear_busy) busy_bad++;
        if (fb_we) begin
          if (int'(fb_addr) != nwr || fb_wdata != 16'h001F || vga_xpos != 0) bad++;
          if (fb_addr == 15'd19199) last_seen = 1;
          nwr++;
        end
      end
      cyc();
    end
    chk("clr_finished", fin, 1);
    chk("clr_writes", nwr, 19200);
    chk("clr_bad_writes", bad, 0);
    chk("clr_busy_gaps", busy_bad, 0);
    chk("clr_early_done", early_done, 0);
    @(negedge vga_clk);
    chk("clr_done_once", clear_done, 0);
    chk("clr_we_idle", fb_we, 0);
    cyc();

    // Read the cleared image back through the scan port
    vga_xpos = 10'd9; vga_ypos = 10'd9;
    cyc();
    vga_xpos = 10'd640; vga_ypos = 10'd480;
    @(negedge vga_clk);
    chk("rb_fifo_pixel", vga_data, 16'hAAAA);
    chk("rb_last_addr", fb_addr, 19199);
    cyc();
    vga_xpos = '0; vga_ypos = '0;
    @(negedge vga_clk);
    chk("rb_last_pixel", vga_data, 16'h001F);
    cyc();

    // Reset mid-clear with a parked FIFO entry: both abandoned
    clear_start = 1'b1; clear_color = 16'h1234;
    cyc();
    clear_start = 1'b0;
    repeat (50) cyc();
    wr_valid = 1'b1; wr_x = 8'd3; wr_y = 7'd3; wr_color = 16'hBEEF;
    cyc();
    wr_valid = 1'b0; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge vga_clk);
    chk("mrst_busy", clear_busy, 0);
    chk("mrst_done", clear_done, 0);
    chk("mrst_ready", wr_ready, 1);
    ndone = 0; nwe = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      @(negedge vga_clk);
      if (clear_done) ndone++;
      if (fb_we) nwe++;
    end
    chk("mrst_no_done", ndone, 0);
    chk("mrst_no_writes", nwe, 0);
    cyc();

    // Random writes and scans against an ordered-write / last-value image model
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      if (k < 380) begin
        wr_valid = ($urandom_range(0, 9) < 6);
        wr_x = 8'($urandom_range(0, 175));
        wr_y = 7'($urandom_range(0, 127));
        wr_color = 16'($urandom);
        if ($urandom_range(0, 9) < 3) begin
          vga_xpos = 10'($urandom_range(1, 640));
          vga_ypos = 10'($urandom_range(1, 480));
        end else begin
          vga_xpos = '0; vga_ypos = '0;
        end
      end else begin
        wr_valid = 1'b0; vga_xpos = '0; vga_ypos = '0;
      end
      @(negedge vga_clk);
      if (vga_xpos != 0) begin
        exp_addr = ((int'(vga_ypos) - 1) / 4) * 160 + (int'(vga_xpos) - 1) / 4;
        chk("rnd_scan_addr", fb_addr, exp_addr);
        chk("rnd_scan_we", fb_we, 0);
      end else if (fb_we) begin
        if (exp_q.size() == 0) bad++;
        else begin
          head = exp_q.pop_front();
          if ({fb_addr, fb_wdata} !== head) bad++;
        end
      end
      if (wr_valid && wr_ready && wr_x < 160 && wr_y < 120) begin
        exp_addr = int'(wr_y) * 160 + int'(wr_x);
        exp_q.push_back({15'(exp_addr), wr_color});
        exp_fb[exp_addr] = wr_color;
      end
      cyc();
    end
    chk("rnd_write_order", bad, 0);
    chk("rnd_all_written", exp_q.size(), 0);

    nrd = 0;
    foreach (exp_fb[a]) begin
      if (nrd < 16) begin
        vga_xpos = 10'((a % 160) * 4 + 1 + $urandom_range(0, 3));
        vga_ypos = 10'((a / 160) * 4 + 1 + $urandom_range(0, 3));
        cyc();
        vga_xpos = '0; vga_ypos = '0;
        @(negedge vga_clk);
        chk("rnd_readback", vga_data, exp_fb[a]);
        cyc();
        nrd++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameters SHALL be:
- FB_W, 160, framebuffer width in pixels.
- FB_H, 120, framebuffer height in pixels.
- SCALE_SHIFT, 2, log2 of the screen-to-framebuffer upscale factor.
- FIFO_DEPTH, 4, write FIFO entries.

REQ-002 Ports SHALL be:
- vga_clk  in  1  sole clock.
- rst_n  in  1  reset; synchronous, active-low.
- vga_xpos  in  10  scan column; 1..640 while a pixel is requested, 0 otherwise.
- vga_ypos  in  10  scan row; 1..480 while a pixel is requested, 0 otherwise.
- vga_data  out  16  RGB565 pixel returned to the scanout.
- wr_valid  in  1  write request.
- wr_ready  out  1  write FIFO can accept.
- wr_x  in  8  framebuffer column.
- wr_y  in  7  framebuffer row.
- wr_color  in  16  RGB565 write data.
- clear_start  in  1  one-cycle pulse; fill the whole frame.
- clear_color  in  16  fill colour, sampled on an accepted clear_start.
- clear_busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse when a clear completes.
- fb_addr  out  15  single-port RAM address.
- fb_we  out  1  RAM write enable.
- fb_wdata  out  16  RAM write data.
- fb_rdata  in  16  RAM read data; valid one cycle after the address.

Function
REQ-003 A scan request SHALL be defined as scan_req = (vga_xpos != 0) && (vga_ypos != 0).
REQ-004 On scan_req, fb_addr SHALL equal ((vga_ypos-1)>>SCALE_SHIFT)*FB_W + ((vga_xpos-1)>>SCALE_SHIFT), computed combinationally, with fb_we=0.
REQ-005 The multiply by FB_W SHALL be implemented as shift-adds (y<<7 + y<<5); no multiplier.
REQ-006 Port priority each cycle SHALL be, highest first: scan read, then clear write, then FIFO write.
REQ-007 fb_addr, fb_we and fb_wdata SHALL be combinational from the current arbitration winner; with no winner they SHALL be 0.
REQ-008 A registered flag rd_q SHALL equal the previous cycle's scan_req.
REQ-009 vga_data SHALL equal fb_rdata when rd_q=1, else 16'd0; read latency is exactly one cycle.
REQ-010 A write SHALL be pushed into the FIFO when wr_valid && wr_ready; wr_ready SHALL be 1 whenever the FIFO is not full.
REQ-011 Simultaneous push and pop on a full FIFO SHALL NOT be permitted: wr_ready reflects registered fullness only.
REQ-012 A pushed entry SHALL be eligible to write no earlier than the cycle after its push.
REQ-013 The FIFO SHALL pop exactly one entry per cycle it wins the port.
REQ-014 A FIFO entry with wr_x >= FB_W or wr_y >= FB_H SHALL be popped without asserting fb_we.
REQ-015 FIFO addressing SHALL be wr_y*FB_W + wr_x.
REQ-016 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an occupancy count.
REQ-017 The clear FSM SHALL have two states, IDLE and CLEAR.
REQ-018 In IDLE, clear_start SHALL latch clear_color, zero the clear counter and enter CLEAR.
REQ-019 In CLEAR, each cycle the clear FSM wins the port SHALL write the latched colour at the counter address and increment the counter.
REQ-020 After writing address FB_W*FB_H-1 (19199), the FSM SHALL return to IDLE and pulse clear_done for one cycle.
REQ-021 clear_busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-022 clear_start received while in CLEAR SHALL be ignored.
REQ-023 During CLEAR the FIFO SHALL continue to accept writes until full but SHALL NOT drain.

Reset
REQ-024 While rst_n=0 at a vga_clk edge, the block SHALL reset as follows:
- FIFO emptied; wr_ready=1.
- FSM to IDLE; clear counter 0.
- clear_busy=0, clear_done=0, rd_q=0, so vga_data=0.
- Latched colour 0.
REQ-025 A reset during CLEAR SHALL abandon the clear without pulsing clear_done.

Structure
REQ-026 A shared package SHALL hold FB_W, FB_H, SCALE_SHIFT, the FB_SIZE=19200 constant, the RGB565 width and the IDLE/CLEAR state encoding.
REQ-027 The FIFO SHALL be a sub-module, fb_wr_fifo, parameterised by depth and entry width (31 bits: x, y, colour).

Verification
REQ-028 Scan read mapping: vga_xpos=5, vga_ypos=9 -> fb_addr=321, fb_we=0 that cycle; the next cycle, vga_data equals the driven fb_rdata (0xABCD).
REQ-029 Blanking write: scan idle, push (x=10, y=3, 0xF800) -> the following cycle fb_we=1, fb_addr=490, fb_wdata=0xF800.
REQ-030 Backpressure: hold scan_req and push 4 entries -> wr_ready=0 afterwards; on release, 4 consecutive write cycles occur, then wr_ready=1.
REQ-031 Clear: clear_start with clear_color=0x001F in blanking -> 19200 writes of 0x001F; a second clear_start mid-clear has no effect; a single clear_done pulse follows the write to 19199.
REQ-032 Discard and reset:
- Push x=160 -> accepted, with no fb_we.
- Assert rst_n=0 mid-clear -> clear_busy=0 the next cycle and no clear_done.
